sys_trap_seq: RTL and testbench

- Sequencer that consumes the decode-stage Ecall/Ebreak flags from the controller and PCSrcE from branch resolution.
- On an accepted system instruction it freezes fetch and decode, bubbles execute, and drains older instructions through M/W. It then halts the core until an external resume pulse arrives, and releases the pipeline by squashing the system instruction in D.
- Its stall/flush outputs are ORed into the hazard unit's stall/flush nets.
- It keeps trap-cause/PC capture registers and saturating event counters for the testbench and debug.

---
 rtl/sys_trap_seq_if.sv | 25 ++
 rtl/sys_trap_seq.sv | 125 ++++++++++++
 tb/tb_sys_trap_seq.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/sys_trap_seq_if.sv
// Pipeline-side signals of the trap sequencer: decode-stage flags and hazard-unit
// inputs in one direction, stall/flush strobes back to the hazard unit in the other.
interface sys_trap_seq_if;
   logic        EcallD;
   logic        EbreakD;
   logic [31:0] PCD;
   logic        StallD_ext;
   logic        PCSrcE;
   logic        TrapStallF;
   logic        TrapStallD;
   logic        TrapFlushD;
   logic        TrapFlushE;

   // Pipeline/hazard-unit side
   modport master (
      output EcallD, EbreakD, PCD, StallD_ext, PCSrcE,
      input  TrapStallF, TrapStallD, TrapFlushD, TrapFlushE
   );

   // Sequencer side
   modport slave (
      input  EcallD, EbreakD, PCD, StallD_ext, PCSrcE,
      output TrapStallF, TrapStallD, TrapFlushD, TrapFlushE
   );
endinterface

// File: rtl/sys_trap_seq.sv
// ECALL/EBREAK trap sequencer: freezes F/D, drains M/W, halts until resume,
// then squashes the system instruction in D. Keeps trap capture and event counters.
module sys_trap_seq #(
   parameter int DRAIN_CYCLES = 2,
   parameter int CNT_W        = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   sys_trap_seq_if.slave    bus,
   input  logic             resume,
   output logic             Halted,
   output logic [1:0]       TrapCause,
   output logic [31:0]      TrapPC,
   output logic [CNT_W-1:0] EcallCount,
   output logic [CNT_W-1:0] EbreakCount
);

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      DRAIN  = 2'd1,
      HALT   = 2'd2,
      RESUME = 2'd3
   } state_t;

   localparam logic [2:0]       DRAIN_INIT = 3'(DRAIN_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

   state_t     state;
   state_t     next_state;
   logic [2:0] drain_cnt;
   logic       acc;
   logic       stall_f;
   logic       stall_d;
   logic       flush_d;
   logic       flush_e;

   // A wrong-path instruction (PCSrcE) or one held by load-use must not trap
   assign acc = (state == RUN) & (bus.EcallD | bus.EbreakD) & ~bus.PCSrcE & ~bus.StallD_ext;

   always_comb begin
      next_state = state;
      stall_f    = 1'b0;
      stall_d    = 1'b0;
      flush_d    = 1'b0;
      flush_e    = 1'b0;
      case (state)
         RUN: begin
            if (acc) begin
               stall_f    = 1'b1;
               stall_d    = 1'b1;
               flush_e    = 1'b1;
               next_state = DRAIN;
            end
         end
         DRAIN: begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
            if (drain_cnt == 3'd1) begin
               next_state = HALT;
            end
         end
         HALT: begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
            if (resume) begin
               next_state = RESUME;
            end
         end
         RESUME: begin
            // F steps past the trap while D takes a bubble, discarding the trap
            flush_d    = 1'b1;
            next_state = RUN;
         end
         default: begin
            next_state = RUN;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= RUN;
         drain_cnt <= 3'd0;
      end else begin
         state <= next_state;
         if (acc) begin
            drain_cnt <= DRAIN_INIT;
         end else if (state == DRAIN) begin
            drain_cnt <= drain_cnt - 3'd1;
         end
      end
   end

   // EBREAK takes priority when both flags decode in the same instruction
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         TrapPC      <= 32'd0;
         TrapCause   <= 2'b00;
         EcallCount  <= '0;
         EbreakCount <= '0;
      end else if (acc) begin
         TrapPC <= bus.PCD;
         if (bus.EbreakD) begin
            TrapCause <= 2'b10;
            if (EbreakCount != '1) begin
               EbreakCount <= EbreakCount + CNT_ONE;
            end
         end else begin
            TrapCause <= 2'b01;
            if (EcallCount != '1) begin
               EcallCount <= EcallCount + CNT_ONE;
            end
         end
      end
   end

   assign bus.TrapStallF = stall_f;
   assign bus.TrapStallD = stall_d;
   assign bus.TrapFlushD = flush_d;
   assign bus.TrapFlushE = flush_e;
   assign Halted         = (state == HALT);

endmodule

// File: tb/tb_sys_trap_seq.sv
// Directed bench for sys_trap_seq (DRAIN_CYCLES=2, CNT_W=4): a vector table for the
// main trap flow plus hand sequences for long HALT, resets and counter saturation.
module tb_sys_trap_seq;

   logic        clk;
   logic        rst_n;
   logic        resume;
   logic        Halted;
   logic [1:0]  TrapCause;
   logic [31:0] TrapPC;
   logic [3:0]  EcallCount;
   logic [3:0]  EbreakCount;

   int tests;
   int fails;

   sys_trap_seq_if bus ();

   sys_trap_seq #(
      .DRAIN_CYCLES(2),
      .CNT_W       (4)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (bus),
      .resume     (resume),
      .Halted     (Halted),
      .TrapCause  (TrapCause),
      .TrapPC     (TrapPC),
      .EcallCount (EcallCount),
      .EbreakCount(EbreakCount)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Strobe order: {TrapStallF, TrapStallD, TrapFlushD, TrapFlushE, Halted}
   localparam logic [4:0] S_IDLE = 5'b00000;
   localparam logic [4:0] S_TRAP = 5'b11010;
   localparam logic [4:0] S_HALT = 5'b11011;
   localparam logic [4:0] S_RES  = 5'b00100;

   typedef struct {
      logic        ecall;
      logic        ebreak;
      logic [31:0] pcd;
      logic        stall;
      logic        pcsrc;
      logic        res;
      logic        rstn;
      logic [4:0]  strb;
      logic [1:0]  cause;
      logic [31:0] tpc;
      logic [3:0]  ecnt;
      logic [3:0]  bcnt;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic e, logic b, logic [31:0] pc, logic st, logic ps,
                               logic rs, logic rn, logic [4:0] strb, logic [1:0] cause,
                               logic [31:0] tpc, logic [3:0] ec, logic [3:0] bc);
      vec_t v;
      v.ecall = e;  v.ebreak = b; v.pcd = pc;  v.stall = st; v.pcsrc = ps;
      v.res   = rs; v.rstn   = rn; v.strb = strb; v.cause = cause;
      v.tpc   = tpc; v.ecnt  = ec; v.bcnt = bc;
      return v;
   endfunction

   function automatic logic [4:0] strobes();
      return {bus.TrapStallF, bus.TrapStallD, bus.TrapFlushD, bus.TrapFlushE, Halted};
   endfunction

   // Drives one cycle's inputs at the falling edge; outputs settle #1 later
   task automatic apply_stimulus(input logic e, input logic b, input logic [31:0] pc,
                                 input logic st, input logic ps, input logic rs,
                                 input logic rn);
      @(negedge clk);
      bus.EcallD     = e;
      bus.EbreakD    = b;
      bus.PCD        = pc;
      bus.StallD_ext = st;
      bus.PCSrcE     = ps;
      resume         = rs;
      rst_n          = rn;
      #1;
   endtask

   task automatic check_output(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      apply_stimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      apply_stimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   // One full ECALL/EBREAK trap with the flag held visible throughout; ends in RESUME
   task automatic run_trap(input logic b, input logic [31:0] pc);
      apply_stimulus(~b, b, pc, 1'b0, 1'b0, 1'b0, 1'b1);
      apply_stimulus(~b, b, pc, 1'b0, 1'b0, 1'b0, 1'b1);
      apply_stimulus(~b, b, pc, 1'b0, 1'b0, 1'b0, 1'b1);
      apply_stimulus(~b, b, pc, 1'b0, 1'b0, 1'b1, 1'b1);
      apply_stimulus(~b, b, pc, 1'b0, 1'b0, 1'b0, 1'b1);
   endtask

   initial begin
      tests = 0;
      fails = 0;
      bus.EcallD = 1'b0; bus.EbreakD = 1'b0; bus.PCD = 32'h0;
      bus.StallD_ext = 1'b0; bus.PCSrcE = 1'b0;
      resume = 1'b0; rst_n = 1'b0;

      //                e     b     pc          st    ps    res   rn    strb    cause  tpc         ec    bc
      vecs.push_back(mk(1'b0, 1'b0, 32'h0,      1'b0, 1'b0, 1'b0, 1'b1, S_IDLE, 2'b00, 32'h0,      4'd0, 4'd0));
      vecs.push_back(mk(1'b1, 1'b0, 32'h40,     1'b0, 1'b1, 1'b0, 1'b1, S_IDLE, 2'b00, 32'h0,      4'd0, 4'd0));
      vecs.push_back(mk(1'b1, 1'b0, 32'h40,     1'b1, 1'b0, 1'b0, 1'b1, S_IDLE, 2'b00, 32'h0,      4'd0, 4'd0));
      vecs.push_back(mk(1'b1, 1'b0, 32'h40,     1'b0, 1'b0, 1'b0, 1'b1, S_TRAP, 2'b00, 32'h0,      4'd0, 4'd0));
      vecs.push_back(mk(1'b1, 1'b0, 32'h40,     1'b0, 1'b0, 1'b0, 1'b1, S_TRAP, 2'b01, 32'h40,     4'd1, 4'd0));
      vecs.push_back(mk(1'b1, 1'b0, 32'h40,     1'b0, 1'b0, 1'b1, 1'b1, S_TRAP, 2'b01, 32'h40,     4'd1, 4'd0));
      vecs.push_back(mk(1'b1, 1'b0, 32'h40,     1'b0, 1'b0, 1'b0, 1'b1, S_HALT, 2'b01, 32'h40,     4'd1, 4'd0));
      vecs.push_back(mk(1'b1, 1'b0, 32'h40,     1'b0, 1'b0, 1'b0, 1'b1, S_HALT, 2'b01, 32'h40,     4'd1, 4'd0));
      vecs.push_back(mk(1'b1, 1'b0, 32'h40,     1'b0, 1'b0, 1'b1, 1'b1, S_HALT, 2'b01, 32'h40,     4'd1, 4'd0));
      vecs.push_back(mk(1'b1, 1'b0, 32'h40,     1'b0, 1'b0, 1'b0, 1'b1, S_RES,  2'b01, 32'h40,     4'd1, 4'd0));
      vecs.push_back(mk(1'b0, 1'b0, 32'h44,     1'b0, 1'b0, 1'b0, 1'b1, S_IDLE, 2'b01, 32'h40,     4'd1, 4'd0));
      vecs.push_back(mk(1'b1, 1'b1, 32'h100,    1'b0, 1'b0, 1'b0, 1'b1, S_TRAP, 2'b01, 32'h40,     4'd1, 4'd0));
      vecs.push_back(mk(1'b1, 1'b1, 32'h100,    1'b0, 1'b0, 1'b0, 1'b1, S_TRAP, 2'b10, 32'h100,    4'd1, 4'd1));
      vecs.push_back(mk(1'b1, 1'b1, 32'h100,    1'b0, 1'b0, 1'b0, 1'b1, S_TRAP, 2'b10, 32'h100,    4'd1, 4'd1));
      vecs.push_back(mk(1'b1, 1'b1, 32'h100,    1'b0, 1'b0, 1'b0, 1'b1, S_HALT, 2'b10, 32'h100,    4'd1, 4'd1));
      vecs.push_back(mk(1'b1, 1'b1, 32'h100,    1'b0, 1'b0, 1'b1, 1'b1, S_HALT, 2'b10, 32'h100,    4'd1, 4'd1));
      vecs.push_back(mk(1'b0, 1'b0, 32'h104,    1'b0, 1'b0, 1'b0, 1'b1, S_RES,  2'b10, 32'h100,    4'd1, 4'd1));
      vecs.push_back(mk(1'b1, 1'b0, 32'h200,    1'b0, 1'b0, 1'b0, 1'b1, S_TRAP, 2'b10, 32'h100,    4'd1, 4'd1));
      vecs.push_back(mk(1'b1, 1'b0, 32'h200,    1'b0, 1'b0, 1'b0, 1'b0, S_TRAP, 2'b01, 32'h200,    4'd2, 4'd1));
      vecs.push_back(mk(1'b0, 1'b0, 32'h0,      1'b0, 1'b0, 1'b0, 1'b1, S_IDLE, 2'b00, 32'h0,      4'd0, 4'd0));

      $display("[TB] reset and vector table");
      do_reset();
      foreach (vecs[i]) begin
         apply_stimulus(vecs[i].ecall, vecs[i].ebreak, vecs[i].pcd, vecs[i].stall,
                        vecs[i].pcsrc, vecs[i].res, vecs[i].rstn);
         check_output($sformatf("v%0d strobes", i), 32'(strobes()),    32'(vecs[i].strb));
         check_output($sformatf("v%0d cause", i),   32'(TrapCause),    32'(vecs[i].cause));
         check_output($sformatf("v%0d trap_pc", i), TrapPC,            vecs[i].tpc);
         check_output($sformatf("v%0d ecalls", i),  32'(EcallCount),   32'(vecs[i].ecnt));
         check_output($sformatf("v%0d ebreaks", i), 32'(EbreakCount),  32'(vecs[i].bcnt));
      end

      $display("[TB] ebreak saturation with back-to-back traps");
      do_reset();
      for (int i = 1; i <= 17; i++) begin
         run_trap(1'b1, 32'h1000 + 32'(i * 4));
         check_output($sformatf("sat%0d resume strobes", i), 32'(strobes()), 32'(S_RES));
         check_output($sformatf("sat%0d ebreaks", i), 32'(EbreakCount), (i > 15) ? 32'd15 : 32'(i));
      end
      check_output("sat trap_pc", TrapPC, 32'h1044);
      check_output("sat ecalls", 32'(EcallCount), 32'd0);

      $display("[TB] ecall right after resume, then long halt");
      apply_stimulus(1'b1, 1'b0, 32'h2000, 1'b0, 1'b0, 1'b0, 1'b1);
      check_output("b2b accept strobes", 32'(strobes()), 32'(S_TRAP));
      apply_stimulus(1'b1, 1'b0, 32'h2000, 1'b0, 1'b0, 1'b0, 1'b1);
      check_output("b2b trap_pc", TrapPC, 32'h2000);
      check_output("b2b cause", 32'(TrapCause), 32'd1);
      check_output("b2b ecalls", 32'(EcallCount), 32'd1);
      apply_stimulus(1'b1, 1'b0, 32'h2000, 1'b0, 1'b0, 1'b1, 1'b1);
      check_output("drain resume ignored", 32'(strobes()), 32'(S_TRAP));
      for (int i = 0; i < 20; i++) begin
         apply_stimulus(1'b1, 1'b0, 32'h2000, 1'b0, 1'b0, 1'b0, 1'b1);
         check_output($sformatf("hold halt %0d", i), 32'(strobes()), 32'(S_HALT));
      end
      apply_stimulus(1'b1, 1'b0, 32'h2000, 1'b0, 1'b0, 1'b1, 1'b1);
      apply_stimulus(1'b1, 1'b0, 32'h2000, 1'b0, 1'b0, 1'b0, 1'b1);
      check_output("late resume strobes", 32'(strobes()), 32'(S_RES));
      apply_stimulus(1'b0, 1'b0, 32'h2004, 1'b0, 1'b0, 1'b0, 1'b1);
      check_output("back in run strobes", 32'(strobes()), 32'(S_IDLE));

      $display("[TB] reset during halt");
      run_trap(1'b0, 32'h3000);
      apply_stimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
      run_trap(1'b0, 32'h3100);
      apply_stimulus(1'b1, 1'b0, 32'h3200, 1'b0, 1'b0, 1'b0, 1'b1);
      apply_stimulus(1'b1, 1'b0, 32'h3200, 1'b0, 1'b0, 1'b0, 1'b1);
      apply_stimulus(1'b1, 1'b0, 32'h3200, 1'b0, 1'b0, 1'b0, 1'b1);
      apply_stimulus(1'b1, 1'b0, 32'h3200, 1'b0, 1'b0, 1'b0, 1'b1);
      check_output("pre-reset halt", 32'(strobes()), 32'(S_HALT));
      check_output("pre-reset ecalls", 32'(EcallCount), 32'd4);
      apply_stimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      apply_stimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
      check_output("halt reset strobes", 32'(strobes()), 32'(S_IDLE));
      check_output("halt reset trap_pc", TrapPC, 32'h0);
      check_output("halt reset cause", 32'(TrapCause), 32'd0);
      check_output("halt reset ecalls", 32'(EcallCount), 32'd0);
      check_output("halt reset ebreaks", 32'(EbreakCount), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
